// File: rtl/matmul_pkg.sv
// Shared types and constants for the 3x3 matrix-multiply control sequencer.
// Holds the FSM state type, operand/result geometry and step-to-(row,col) helpers.
package matmul_pkg;

    localparam int DIM        = 3;
    localparam int N_OPERANDS = 18;
    localparam int N_RESULTS  = 9;
    localparam int LD_ADDR_W  = 5;
    localparam int RES_ADDR_W = 4;
    localparam int RD_SEL_W   = 9;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_COMPUTE = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    localparam logic [LD_ADDR_W-1:0]  LAST_OPERAND = LD_ADDR_W'(N_OPERANDS - 1);
    localparam logic [RES_ADDR_W-1:0] LAST_RESULT  = RES_ADDR_W'(N_RESULTS - 1);

    // Result index is row-major over a DIM x DIM grid.
    function automatic logic [1:0] step_row(input logic [RES_ADDR_W-1:0] step);
        logic [1:0] row;
        case (step)
            4'd0, 4'd1, 4'd2: row = 2'd0;
            4'd3, 4'd4, 4'd5: row = 2'd1;
            default:          row = 2'd2;
        endcase
        return row;
    endfunction

    function automatic logic [1:0] step_col(input logic [RES_ADDR_W-1:0] step);
        logic [1:0] col;
        case (step)
            4'd0, 4'd3, 4'd6: col = 2'd0;
            4'd1, 4'd4, 4'd7: col = 2'd1;
            default:          col = 2'd2;
        endcase
        return col;
    endfunction

endpackage

// File: rtl/seq_onehot9_decoder.sv
// Readout decoder: 4-bit result index plus enable to a one-hot output enable,
// flagging indices beyond the last result register.
module seq_onehot9_decoder
    import matmul_pkg::*;
(
    input  logic [RES_ADDR_W-1:0] idx_i,
    input  logic                  en_i,
    output logic [RD_SEL_W-1:0]   onehot_o,
    output logic                  oor_o
);

    // Decode index when enabled; out-of-range indices raise the flag instead.
    always_comb begin
        onehot_o = 9'd0;
        oor_o    = 1'b0;
        if (en_i) begin
            if (idx_i <= LAST_RESULT) begin
                onehot_o = 9'd1 << idx_i;
            end else begin
                oor_o = 1'b1;
            end
        end else begin
            onehot_o = 9'd0;
            oor_o    = 1'b0;
        end
    end

endmodule

// File: rtl/matmul_sequencer.sv
// Control sequencer for a 3x3 matrix multiply: loads 18 operand nibbles,
// steps 9 result writes, then serves one-hot readout in DONE.
module matmul_sequencer
    import matmul_pkg::*;
(
    input  logic                  ic,
    input  logic                  mr,
    input  logic                  en,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  ld_we,
    output logic [LD_ADDR_W-1:0]  ld_addr,
    output logic [1:0]            row_sel,
    output logic [1:0]            col_sel,
    output logic                  res_we,
    output logic [RES_ADDR_W-1:0] res_addr,
    output logic                  busy,
    output logic                  done,
    input  logic                  rd_en,
    input  logic [RES_ADDR_W-1:0] rd_addr,
    output logic [RD_SEL_W-1:0]   rd_sel,
    output logic                  rd_err
);

    state_e                  state_q, state_d;
    logic [LD_ADDR_W-1:0]    cnt_q, cnt_d;
    logic [RES_ADDR_W-1:0]   step_q, step_d;

    // Next-state logic; en=0 holds everything and abort outranks start.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        step_d  = step_q;
        if (en) begin
            if (abort) begin
                state_d = ST_IDLE;
                cnt_d   = 5'd0;
                step_d  = 4'd0;
            end else begin
                case (state_q)
                    ST_IDLE, ST_DONE: begin
                        if (start) begin
                            state_d = ST_LOAD;
                            cnt_d   = 5'd0;
                            step_d  = 4'd0;
                        end else begin
                            state_d = state_q;
                        end
                    end
                    ST_LOAD: begin
                        if (in_valid) begin
                            if (cnt_q == LAST_OPERAND) begin
                                state_d = ST_COMPUTE;
                                step_d  = 4'd0;
                            end else begin
                                cnt_d = cnt_q + 5'd1;
                            end
                        end else begin
                            cnt_d = cnt_q;
                        end
                    end
                    ST_COMPUTE: begin
                        if (step_q == LAST_RESULT) begin
                            state_d = ST_DONE;
                        end else begin
                            step_d = step_q + 4'd1;
                        end
                    end
                    default: begin
                        state_d = ST_IDLE;
                        cnt_d   = 5'd0;
                        step_d  = 4'd0;
                    end
                endcase
            end
        end else begin
            state_d = state_q;
        end
    end

    // State and counter registers with synchronous active-low master reset.
    always_ff @(posedge ic) begin
        if (!mr) begin
            state_q <= ST_IDLE;
            cnt_q   <= 5'd0;
            step_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            step_q  <= step_d;
        end
    end

    // Strobes are combinational so the write lands in the accepting cycle.
    assign in_ready = en & (state_q == ST_LOAD);
    assign ld_we    = in_ready & in_valid & ~abort;
    assign res_we   = en & (state_q == ST_COMPUTE) & ~abort;
    assign ld_addr  = cnt_q;
    assign res_addr = step_q;
    assign row_sel  = step_row(step_q);
    assign col_sel  = step_col(step_q);
    assign busy     = (state_q == ST_LOAD) | (state_q == ST_COMPUTE);
    assign done     = (state_q == ST_DONE);

    seq_onehot9_decoder u_rd_dec (
        .idx_i    (rd_addr),
        .en_i     (rd_en & en & (state_q == ST_DONE)),
        .onehot_o (rd_sel),
        .oor_o    (rd_err)
    );

endmodule

// File: tb/tb_matmul_sequencer.sv
// Self-checking bench for matmul_sequencer: directed operations with a
// progress-count reference model compared on every falling edge.
module tb_matmul_sequencer;

    logic       ic = 1'b0;
    logic       mr = 1'b0;
    logic       en = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       in_valid = 1'b0;
    logic       rd_en = 1'b0;
    logic [3:0] rd_addr = 4'd0;
    logic       in_ready, ld_we, res_we, busy, done, rd_err;
    logic [4:0] ld_addr;
    logic [1:0] row_sel, col_sel;
    logic [3:0] res_addr;
    logic [8:0] rd_sel;

    int  n_cmp = 0;
    int  n_bad = 0;
    bit  chk_on = 1'b0;

    // Reference: how far the current operation has progressed.
    bit  m_active = 1'b0;
    int  m_loaded = 0;
    int  m_computed = 0;

    matmul_sequencer dut (
        .ic(ic), .mr(mr), .en(en), .start(start), .abort(abort),
        .in_valid(in_valid), .in_ready(in_ready), .ld_we(ld_we), .ld_addr(ld_addr),
        .row_sel(row_sel), .col_sel(col_sel), .res_we(res_we), .res_addr(res_addr),
        .busy(busy), .done(done), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_sel(rd_sel), .rd_err(rd_err)
    );

    always #5 ic = ~ic;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge ic);
        #1;
    endtask

    always @(posedge ic) begin
        if (!mr) begin
            m_active = 1'b0; m_loaded = 0; m_computed = 0;
        end else if (en) begin
            if (abort) begin
                m_active = 1'b0; m_loaded = 0; m_computed = 0;
            end else if ((!m_active || m_computed == 9) && start) begin
                m_active = 1'b1; m_loaded = 0; m_computed = 0;
            end else if (m_active && m_loaded < 18) begin
                if (in_valid) m_loaded++;
            end else if (m_active && m_computed < 9) begin
                m_computed++;
            end
        end
    end

    always @(negedge ic) begin
        bit         ph_ld, ph_cp, ph_dn;
        int         la, ra;
        logic [8:0] es;
        if (chk_on) begin
            ph_ld = m_active && m_loaded < 18;
            ph_cp = m_active && m_loaded == 18 && m_computed < 9;
            ph_dn = m_active && m_computed == 9;
            la = (m_loaded > 17) ? 17 : m_loaded;
            ra = (m_computed > 8) ? 8 : m_computed;
            es = (ph_dn && en && rd_en && rd_addr <= 4'd8) ? (9'd1 << rd_addr) : 9'd0;
            check("m_in_ready", 32'(in_ready), 32'(en && ph_ld));
            check("m_ld_we",    32'(ld_we),    32'(en && ph_ld && in_valid && !abort));
            check("m_ld_addr",  32'(ld_addr),  32'(la));
            check("m_res_we",   32'(res_we),   32'(en && ph_cp && !abort));
            check("m_res_addr", 32'(res_addr), 32'(ra));
            check("m_row_sel",  32'(row_sel),  32'(ra / 3));
            check("m_col_sel",  32'(col_sel),  32'(ra % 3));
            check("m_busy",     32'(busy),     32'(ph_ld || ph_cp));
            check("m_done",     32'(done),     32'(ph_dn));
            check("m_rd_sel",   32'(rd_sel),   32'(es));
            check("m_rd_err",   32'(rd_err),   32'(ph_dn && en && rd_en && rd_addr > 4'd8));
            check("m_we_excl",  32'(ld_we & res_we), 32'd0);
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_ld_we"},    32'(ld_we),    32'd0);
        check({tag, "_ld_addr"},  32'(ld_addr),  32'd0);
        check({tag, "_row_sel"},  32'(row_sel),  32'd0);
        check({tag, "_col_sel"},  32'(col_sel),  32'd0);
        check({tag, "_res_we"},   32'(res_we),   32'd0);
        check({tag, "_res_addr"}, 32'(res_addr), 32'd0);
        check({tag, "_busy"},     32'(busy),     32'd0);
        check({tag, "_done"},     32'(done),     32'd0);
        check({tag, "_rd_sel"},   32'(rd_sel),   32'd0);
        check({tag, "_rd_err"},   32'(rd_err),   32'd0);
    endtask

    // One operation from IDLE/DONE; optional gaps, en-off, abort or reset points.
    task automatic drive_op(input bit gaps, input int en_off_step, input int abort_step,
                            input int reset_idx, input int exp_lat, input bit start_noise);
        int lat;
        int s;
        bit off_done;
        int row_tab[9];
        int col_tab[9];
        row_tab = '{0, 0, 0, 1, 1, 1, 2, 2, 2};
        col_tab = '{0, 1, 2, 0, 1, 2, 0, 1, 2};
        off_done = 1'b0;
        start = 1'b1;
        tick();
        lat = 1;
        start = start_noise;
        for (int i = 0; i < 18; i++) begin
            if (gaps && (i == 5 || i == 12)) begin
                in_valid = 1'b0;
                for (int g = 0; g < 3; g++) begin
                    #1;
                    check("gap_ld_we", 32'(ld_we), 32'd0);
                    check("gap_ld_addr", 32'(ld_addr), 32'(i));
                    tick();
                    lat++;
                end
            end
            in_valid = 1'b1;
            if (i == reset_idx) begin
                mr = 1'b0;
                tick();
                mr = 1'b1;
                start = 1'b0;
                #1;
                check_reset_outputs("mr_load");
                in_valid = 1'b0;
                return;
            end
            #1;
            check("ld_we", 32'(ld_we), 32'd1);
            check("ld_addr", 32'(ld_addr), 32'(i));
            tick();
            lat++;
        end
        in_valid = 1'b0;
        s = 0;
        while (done !== 1'b1 && lat < 60) begin
            if (s == abort_step) begin
                abort = 1'b1;
                start = 1'b1;
                #1;
                check("abort_res_we", 32'(res_we), 32'd0);
                tick();
                abort = 1'b0;
                start = 1'b0;
                #1;
                check("abort_busy", 32'(busy), 32'd0);
                check("abort_done", 32'(done), 32'd0);
                check("abort_res_addr", 32'(res_addr), 32'd0);
                return;
            end
            if (s == en_off_step && !off_done) begin
                en = 1'b0;
                for (int g = 0; g < 2; g++) begin
                    #1;
                    check("enoff_res_we", 32'(res_we), 32'd0);
                    check("enoff_res_addr", 32'(res_addr), 32'(s));
                    tick();
                    lat++;
                end
                en = 1'b1;
                off_done = 1'b1;
            end
            #1;
            if (s < 9) begin
                check("res_we", 32'(res_we), 32'd1);
                check("res_addr", 32'(res_addr), 32'(s));
                check("row_sel", 32'(row_sel), 32'(row_tab[s]));
                check("col_sel", 32'(col_sel), 32'(col_tab[s]));
            end else begin
                check("compute_overrun", 32'(s), 32'd8);
            end
            tick();
            lat++;
            s++;
        end
        start = 1'b0;
        check("latency", 32'(lat), 32'(exp_lat));
        check("done_level", 32'(done), 32'd1);
    endtask

    task automatic reload_from_zero(input string tag);
        start = 1'b1;
        tick();
        start = 1'b0;
        in_valid = 1'b1;
        #1;
        check({tag, "_ld_we"}, 32'(ld_we), 32'd1);
        check({tag, "_ld_addr"}, 32'(ld_addr), 32'd0);
        tick();
        in_valid = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    initial begin
        mr = 1'b0;
        tick();
        chk_on = 1'b1;
        tick();
        check_reset_outputs("reset");
        mr = 1'b1;
        tick();

        // Start ignored while disabled.
        en = 1'b0;
        start = 1'b1;
        tick();
        check("en0_start_busy", 32'(busy), 32'd0);
        en = 1'b1;
        start = 1'b0;

        drive_op(1'b0, -1, -1, -1, 28, 1'b0);

        rd_en = 1'b1;
        rd_addr = 4'd7;
        #1;
        check("rd_sel_7", 32'(rd_sel), 32'h080);
        check("rd_err_7", 32'(rd_err), 32'd0);
        tick();
        rd_addr = 4'd12;
        #1;
        check("rd_sel_12", 32'(rd_sel), 32'd0);
        check("rd_err_12", 32'(rd_err), 32'd1);
        tick();
        rd_addr = 4'd8;
        #1;
        check("rd_sel_8", 32'(rd_sel), 32'h100);
        tick();
        rd_addr = 4'd9;
        en = 1'b0;
        #1;
        check("rd_err_en0", 32'(rd_err), 32'd0);
        tick();
        en = 1'b1;
        rd_addr = 4'd0;
        #1;
        check("rd_sel_0", 32'(rd_sel), 32'h001);
        tick();
        rd_en = 1'b0;

        drive_op(1'b1, -1, -1, -1, 34, 1'b1);
        drive_op(1'b0, 4, -1, -1, 30, 1'b0);
        drive_op(1'b0, -1, 6, -1, 0, 1'b0);
        reload_from_zero("abort_reload");
        drive_op(1'b0, -1, -1, 10, 0, 1'b0);
        reload_from_zero("mr_reload");
        tick();

        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1);
    end

endmodule
